// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer for the ALU shift path.
// One request at a time is accepted in IDLE, the operand is shifted by at most
// SHIFT_STEP bits per cycle in SHIFT, and the result is presented in DONE with a
// one-cycle done pulse. Ready/busy/done/err/result are all registered.
module shift_seq_ctrl #(
  parameter int unsigned SHIFT_STEP = 32'd1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic [3:0]  ctrl_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic [4:0]  shamt_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] result_o
);

  localparam logic [3:0] OP_SLL  = 4'd0;
  localparam logic [3:0] OP_SRL  = 4'd1;
  localparam logic [3:0] OP_SRA  = 4'd2;
  localparam logic [3:0] OP_SLLV = 4'd3;
  localparam logic [3:0] OP_SRLV = 4'd4;
  localparam logic [3:0] OP_SRAV = 4'd5;

  // Step size as a 6-bit value so that a step of 32 is representable.
  localparam logic [5:0] STEP_MAX = 6'(SHIFT_STEP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_acc;
  logic [4:0]  r_cnt;
  logic [3:0]  r_op;

  logic        w_is_var;
  logic        w_legal;
  logic        w_req;
  logic [4:0]  w_amt;
  logic [4:0]  w_step;
  logic [4:0]  w_cnt_rem;
  logic [31:0] w_acc_sh;

  // Upper rs bits never contribute to the shift amount.
  logic        w_unused_src1;
  assign w_unused_src1 = ^src1_i[31:5];

  // Decode the incoming request: amount source, legality and the effective strobe.
  always_comb begin
    w_is_var = (ctrl_i == OP_SLLV) || (ctrl_i == OP_SRLV) || (ctrl_i == OP_SRAV);
    w_legal  = (ctrl_i <= OP_SRAV);
    if (w_is_var) begin
      w_amt = src1_i[4:0];
    end else begin
      w_amt = shamt_i;
    end
    w_req = start_i && !flush_i;
  end

  // One shift step: min(cnt, SHIFT_STEP) bits in the direction/fill of the latched op.
  always_comb begin
    if ({1'b0, r_cnt} < STEP_MAX) begin
      w_step = r_cnt;
    end else begin
      w_step = STEP_MAX[4:0];
    end
    w_cnt_rem = r_cnt - w_step;
    case (r_op)
      OP_SLL, OP_SLLV: w_acc_sh = r_acc << w_step;
      OP_SRL, OP_SRLV: w_acc_sh = r_acc >> w_step;
      // Arithmetic shift keeps bit 31, so the sign latched from src2 persists.
      OP_SRA, OP_SRAV: w_acc_sh = $signed(r_acc) >>> w_step;
      default:         w_acc_sh = r_acc;
    endcase
  end

  // Next-state logic; flush only matters in SHIFT (and blocks acceptance in IDLE).
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if ((w_amt == 5'd0) || !w_legal) begin
            w_next = ST_DONE;
          end else begin
            w_next = ST_SHIFT;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (flush_i) begin
          w_next = ST_IDLE;
        end else if (w_cnt_rem == 5'd0) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_SHIFT;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Working registers: latch the request on accept, then iterate while shifting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc <= 32'd0;
      r_cnt <= 5'd0;
      r_op  <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_acc <= src2_i;
            r_cnt <= w_amt;
            r_op  <= ctrl_i;
          end
        end
        ST_SHIFT: begin
          if (!flush_i) begin
            r_acc <= w_acc_sh;
            r_cnt <= w_cnt_rem;
          end
        end
        default: begin
          r_acc <= r_acc;
        end
      endcase
    end
  end

  // Registered outputs; result/err load only on the edge entering DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_o  <= 1'b1;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      result_o <= 32'd0;
    end else begin
      ready_o <= (w_next == ST_IDLE);
      busy_o  <= (w_next != ST_IDLE);
      done_o  <= (w_next == ST_DONE) && (r_state != ST_DONE);
      case (r_state)
        ST_IDLE: begin
          // Zero amount or illegal op: the operand passes through unchanged.
          if (w_req && (w_next == ST_DONE)) begin
            result_o <= src2_i;
            err_o    <= !w_legal;
          end
        end
        ST_SHIFT: begin
          if (!flush_i && (w_cnt_rem == 5'd0)) begin
            result_o <= w_acc_sh;
            err_o    <= 1'b0;
          end
        end
        default: begin
          result_o <= result_o;
        end
      endcase
    end
  end

endmodule
